// File: rtl/opram_pkg.sv
// rtl/opram_pkg.sv - shared sizes and types for the operand-ready LUTRAM write path
package opram_pkg;

  localparam int OPRAM_DEPTH = 32;
  localparam int OPRAM_AW    = 5;
  localparam int OPRAM_DW    = 2;

  typedef enum logic {ARB_INIT, ARB_RUN} arb_state_e;

  typedef logic [OPRAM_AW-1:0] opram_addr_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin one-hot picker
// With OPRAM_ARB_PRIO0_EN defined, req[0] wins outright before the rotating search.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
`ifdef OPRAM_ARB_PRIO0_EN
    if (req[0]) begin
      grant[0] = 1'b1;
      found    = 1'b1;
    end
`endif
    // Walk upward from ptr, wrapping modulo NREQ; first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/opram_wr_arbiter.sv
// rtl/opram_wr_arbiter.sv - write-port arbiter and init sweep for the operand-ready LUTRAM
// OPRAM_ARB_PRIO0_EN gives requester 0 fixed top priority over the round-robin group.
module opram_wr_arbiter
  import opram_pkg::*;
#(
  parameter int             NREQ     = 4,
  parameter int             DEPTH    = OPRAM_DEPTH,
  parameter int             AW       = OPRAM_AW,
  parameter int             DW       = OPRAM_DW,
  parameter logic [DW-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              init_busy,
  output logic              ram_wen,
  output logic [AW-1:0]     ram_aw,
  output logic [DW-1:0]     ram_di
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e    state, state_nxt;
  logic [AW-1:0] cnt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [NREQ-1:0] grant;
  logic [PW-1:0] grant_idx;
  logic          granted;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ARB_INIT: if (cnt == AW'(DEPTH-1)) state_nxt = ARB_RUN;
      ARB_RUN:  req_ready = grant;
      default:  state_nxt = ARB_INIT;
    endcase
    if (flush) begin
      state_nxt = ARB_INIT;
      req_ready = '0;
    end
  end

  assign granted = |req_ready;
  assign ptr_nxt = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Flush behaves like an idle cycle on the write port; the sweep starts next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      ptr       <= '0;
      ram_wen   <= 1'b0;
      ram_aw    <= '0;
      ram_di    <= '0;
      init_busy <= 1'b1;
    end else if (flush) begin
      cnt       <= '0;
      ram_wen   <= 1'b0;
      init_busy <= 1'b1;
    end else if (state == ARB_INIT) begin
      ram_wen <= 1'b1;
      ram_aw  <= cnt;
      ram_di  <= INIT_VAL;
      cnt     <= cnt + AW'(1);
      if (cnt == AW'(DEPTH-1)) init_busy <= 1'b0;
    end else if (granted) begin
      ram_wen <= 1'b1;
      ram_aw  <= sel_addr;
      ram_di  <= sel_data;
`ifdef OPRAM_ARB_PRIO0_EN
      if (grant_idx != '0) ptr <= ptr_nxt;
`else
      ptr <= ptr_nxt;
`endif
    end else begin
      ram_wen <= 1'b0;
    end
  end

endmodule
